// File: rtl/rv32i_fetch_decode.sv
// rv32i_fetch_decode: multi-cycle fetch and registered one-hot decode front end
// for a non-pipelined RV32I core. One instruction is fetched, decoded and held
// stable until the core retires it and supplies the next PC.
module rv32i_fetch_decode #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    input  logic        retire,
    input  logic [31:0] next_pc,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [31:0] imm,
    output logic        instr_lui,
    output logic        instr_auipc,
    output logic        instr_jal,
    output logic        instr_jalr,
    output logic        instr_beq,
    output logic        instr_bne,
    output logic        instr_blt,
    output logic        instr_bge,
    output logic        instr_bltu,
    output logic        instr_bgeu,
    output logic        instr_lb,
    output logic        instr_lh,
    output logic        instr_lw,
    output logic        instr_lbu,
    output logic        instr_lhu,
    output logic        instr_sb,
    output logic        instr_sh,
    output logic        instr_sw,
    output logic        instr_addi,
    output logic        instr_slti,
    output logic        instr_sltiu,
    output logic        instr_xori,
    output logic        instr_ori,
    output logic        instr_andi,
    output logic        instr_slli,
    output logic        instr_srli,
    output logic        instr_srai,
    output logic        instr_add,
    output logic        instr_sub,
    output logic        instr_sll,
    output logic        instr_slt,
    output logic        instr_sltu,
    output logic        instr_xor,
    output logic        instr_srl,
    output logic        instr_sra,
    output logic        instr_or,
    output logic        instr_and,
    output logic        instr_fence,
    output logic        instr_fence_tso,
    output logic        instr_pause,
    output logic        instr_ecall,
    output logic        instr_ebreak,
    output logic        instr_csrrw,
    output logic        instr_csrrs,
    output logic        instr_csrrc,
    output logic        instr_csrrwi,
    output logic        instr_csrrsi,
    output logic        instr_csrrci,
    output logic        illegal,
    output logic        fetch_fault
);

    // Bit positions of each mnemonic inside the packed flag vector.
    localparam int F_LUI = 0,  F_AUIPC = 1,  F_JAL = 2,   F_JALR = 3;
    localparam int F_BEQ = 4,  F_BNE = 5,    F_BLT = 6,   F_BGE = 7,   F_BLTU = 8,  F_BGEU = 9;
    localparam int F_LB = 10,  F_LH = 11,    F_LW = 12,   F_LBU = 13,  F_LHU = 14;
    localparam int F_SB = 15,  F_SH = 16,    F_SW = 17;
    localparam int F_ADDI = 18, F_SLTI = 19, F_SLTIU = 20, F_XORI = 21, F_ORI = 22, F_ANDI = 23;
    localparam int F_SLLI = 24, F_SRLI = 25, F_SRAI = 26;
    localparam int F_ADD = 27, F_SUB = 28,   F_SLL = 29,  F_SLT = 30,  F_SLTU = 31;
    localparam int F_XOR = 32, F_SRL = 33,   F_SRA = 34,  F_OR = 35,   F_AND = 36;
    localparam int F_FENCE = 37, F_FENCE_TSO = 38, F_PAUSE = 39, F_ECALL = 40, F_EBREAK = 41;
    localparam int F_CSRRW = 42, F_CSRRS = 43, F_CSRRC = 44;
    localparam int F_CSRRWI = 45, F_CSRRSI = 46, F_CSRRCI = 47;
    localparam int NFLAGS = 48;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [31:0]         pc_q, pc_d;
    logic [31:0]         instr_q, instr_d;
    logic [NFLAGS-1:0]   flags_q, flags_d;
    logic [31:0]         imm_q, imm_d;
    logic                illegal_q, illegal_d;
    logic                fault_q, fault_d;

    logic [NFLAGS-1:0]   dec_flags;
    logic [31:0]         dec_imm;
    logic [6:0]          op;
    logic [2:0]          f3;
    logic [6:0]          f7;
    logic [31:0]         imm_i, imm_s, imm_b, imm_u, imm_j;

    assign op = imem_rsp_data[6:0];
    assign f3 = imem_rsp_data[14:12];
    assign f7 = imem_rsp_data[31:25];

    assign imm_i = {{20{imem_rsp_data[31]}}, imem_rsp_data[31:20]};
    assign imm_s = {{20{imem_rsp_data[31]}}, imem_rsp_data[31:25], imem_rsp_data[11:7]};
    assign imm_b = {{19{imem_rsp_data[31]}}, imem_rsp_data[31], imem_rsp_data[7],
                    imem_rsp_data[30:25], imem_rsp_data[11:8], 1'b0};
    assign imm_u = {imem_rsp_data[31:12], 12'b0};
    assign imm_j = {{11{imem_rsp_data[31]}}, imem_rsp_data[31], imem_rsp_data[19:12],
                    imem_rsp_data[20], imem_rsp_data[30:21], 1'b0};

    // Decode the response word into one-hot flags and its format's immediate.
    always_comb begin
        dec_flags = '0;
        dec_imm   = '0;
        case (op)
            7'b0110111: begin dec_flags[F_LUI]   = 1'b1; dec_imm = imm_u; end
            7'b0010111: begin dec_flags[F_AUIPC] = 1'b1; dec_imm = imm_u; end
            7'b1101111: begin dec_flags[F_JAL]   = 1'b1; dec_imm = imm_j; end
            7'b1100111: begin
                if (f3 == 3'b000) dec_flags[F_JALR] = 1'b1;
                dec_imm = imm_i;
            end
            7'b1100011: begin
                case (f3)
                    3'b000:  dec_flags[F_BEQ]  = 1'b1;
                    3'b001:  dec_flags[F_BNE]  = 1'b1;
                    3'b100:  dec_flags[F_BLT]  = 1'b1;
                    3'b101:  dec_flags[F_BGE]  = 1'b1;
                    3'b110:  dec_flags[F_BLTU] = 1'b1;
                    3'b111:  dec_flags[F_BGEU] = 1'b1;
                    default: dec_flags = '0;
                endcase
                dec_imm = imm_b;
            end
            7'b0000011: begin
                case (f3)
                    3'b000:  dec_flags[F_LB]  = 1'b1;
                    3'b001:  dec_flags[F_LH]  = 1'b1;
                    3'b010:  dec_flags[F_LW]  = 1'b1;
                    3'b100:  dec_flags[F_LBU] = 1'b1;
                    3'b101:  dec_flags[F_LHU] = 1'b1;
                    default: dec_flags = '0;
                endcase
                dec_imm = imm_i;
            end
            7'b0100011: begin
                case (f3)
                    3'b000:  dec_flags[F_SB] = 1'b1;
                    3'b001:  dec_flags[F_SH] = 1'b1;
                    3'b010:  dec_flags[F_SW] = 1'b1;
                    default: dec_flags = '0;
                endcase
                dec_imm = imm_s;
            end
            7'b0010011: begin
                case (f3)
                    3'b000:  dec_flags[F_ADDI]  = 1'b1;
                    3'b010:  dec_flags[F_SLTI]  = 1'b1;
                    3'b011:  dec_flags[F_SLTIU] = 1'b1;
                    3'b100:  dec_flags[F_XORI]  = 1'b1;
                    3'b110:  dec_flags[F_ORI]   = 1'b1;
                    3'b111:  dec_flags[F_ANDI]  = 1'b1;
                    3'b001:  dec_flags[F_SLLI]  = (f7 == 7'b0000000);
                    default: begin
                        dec_flags[F_SRLI] = (f7 == 7'b0000000);
                        dec_flags[F_SRAI] = (f7 == 7'b0100000);
                    end
                endcase
                dec_imm = imm_i;
            end
            7'b0110011: begin
                if (f7 == 7'b0000000) begin
                    case (f3)
                        3'b000:  dec_flags[F_ADD]  = 1'b1;
                        3'b001:  dec_flags[F_SLL]  = 1'b1;
                        3'b010:  dec_flags[F_SLT]  = 1'b1;
                        3'b011:  dec_flags[F_SLTU] = 1'b1;
                        3'b100:  dec_flags[F_XOR]  = 1'b1;
                        3'b101:  dec_flags[F_SRL]  = 1'b1;
                        3'b110:  dec_flags[F_OR]   = 1'b1;
                        default: dec_flags[F_AND]  = 1'b1;
                    endcase
                end else if (f7 == 7'b0100000) begin
                    dec_flags[F_SUB] = (f3 == 3'b000);
                    dec_flags[F_SRA] = (f3 == 3'b101);
                end
            end
            7'b0001111: begin
                // fence.tso and pause are exact encodings of FENCE; anything
                // else with funct3=000 is an ordinary fence.
                if (f3 == 3'b000) begin
                    if (imem_rsp_data == 32'h8330_000F)      dec_flags[F_FENCE_TSO] = 1'b1;
                    else if (imem_rsp_data == 32'h0100_000F) dec_flags[F_PAUSE]     = 1'b1;
                    else                                     dec_flags[F_FENCE]     = 1'b1;
                end
            end
            7'b1110011: begin
                case (f3)
                    3'b000: begin
                        dec_flags[F_ECALL]  = (imem_rsp_data == 32'h0000_0073);
                        dec_flags[F_EBREAK] = (imem_rsp_data == 32'h0010_0073);
                    end
                    3'b001:  dec_flags[F_CSRRW]  = 1'b1;
                    3'b010:  dec_flags[F_CSRRS]  = 1'b1;
                    3'b011:  dec_flags[F_CSRRC]  = 1'b1;
                    3'b101:  dec_flags[F_CSRRWI] = 1'b1;
                    3'b110:  dec_flags[F_CSRRSI] = 1'b1;
                    3'b111:  dec_flags[F_CSRRCI] = 1'b1;
                    default: dec_flags = '0;
                endcase
                if (f3 != 3'b000) dec_imm = imm_i;
            end
            default: dec_flags = '0;
        endcase
        // Unrecognised words carry no immediate.
        if (dec_flags == '0) dec_imm = '0;
    end

    // Next-state and register updates for the fetch/hold sequence.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        flags_d   = flags_q;
        imm_d     = imm_q;
        illegal_d = illegal_q;
        fault_d   = fault_q;
        case (state_q)
            S_RESET: state_d = S_REQ;
            S_REQ: begin
                if (imem_req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    state_d = S_HOLD;
                    instr_d = imem_rsp_data;
                    if (imem_rsp_err) begin
                        fault_d   = 1'b1;
                        flags_d   = '0;
                        imm_d     = '0;
                        illegal_d = 1'b0;
                    end else begin
                        fault_d   = 1'b0;
                        flags_d   = dec_flags;
                        imm_d     = dec_imm;
                        illegal_d = (dec_flags == '0);
                    end
                end
            end
            default: begin
                if (retire) begin
                    pc_d      = next_pc;
                    instr_d   = '0;
                    flags_d   = '0;
                    imm_d     = '0;
                    illegal_d = 1'b0;
                    // A misaligned target is reported in place; only an
                    // aligned retire restarts fetching.
                    if (next_pc[1:0] != 2'b00) begin
                        fault_d = 1'b1;
                    end else begin
                        fault_d = 1'b0;
                        state_d = S_REQ;
                    end
                end
            end
        endcase
    end

    // State register; reset returns to RESET from any state.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_RESET;
        else     state_q <= state_d;
    end

    // PC and decoded instruction registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            instr_q   <= '0;
            flags_q   <= '0;
            imm_q     <= '0;
            illegal_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            flags_q   <= flags_d;
            imm_q     <= imm_d;
            illegal_q <= illegal_d;
            fault_q   <= fault_d;
        end
    end

    assign imem_req_valid = (state_q == S_REQ);
    assign imem_req_addr  = pc_q;
    assign instr_valid    = (state_q == S_HOLD);
    assign pc             = pc_q;
    assign instr          = instr_q;
    assign rd             = instr_q[11:7];
    assign rs1            = instr_q[19:15];
    assign rs2            = instr_q[24:20];
    assign imm            = imm_q;
    assign illegal        = illegal_q;
    assign fetch_fault    = fault_q;

    assign instr_lui       = flags_q[F_LUI];
    assign instr_auipc     = flags_q[F_AUIPC];
    assign instr_jal       = flags_q[F_JAL];
    assign instr_jalr      = flags_q[F_JALR];
    assign instr_beq       = flags_q[F_BEQ];
    assign instr_bne       = flags_q[F_BNE];
    assign instr_blt       = flags_q[F_BLT];
    assign instr_bge       = flags_q[F_BGE];
    assign instr_bltu      = flags_q[F_BLTU];
    assign instr_bgeu      = flags_q[F_BGEU];
    assign instr_lb        = flags_q[F_LB];
    assign instr_lh        = flags_q[F_LH];
    assign instr_lw        = flags_q[F_LW];
    assign instr_lbu       = flags_q[F_LBU];
    assign instr_lhu       = flags_q[F_LHU];
    assign instr_sb        = flags_q[F_SB];
    assign instr_sh        = flags_q[F_SH];
    assign instr_sw        = flags_q[F_SW];
    assign instr_addi      = flags_q[F_ADDI];
    assign instr_slti      = flags_q[F_SLTI];
    assign instr_sltiu     = flags_q[F_SLTIU];
    assign instr_xori      = flags_q[F_XORI];
    assign instr_ori       = flags_q[F_ORI];
    assign instr_andi      = flags_q[F_ANDI];
    assign instr_slli      = flags_q[F_SLLI];
    assign instr_srli      = flags_q[F_SRLI];
    assign instr_srai      = flags_q[F_SRAI];
    assign instr_add       = flags_q[F_ADD];
    assign instr_sub       = flags_q[F_SUB];
    assign instr_sll       = flags_q[F_SLL];
    assign instr_slt       = flags_q[F_SLT];
    assign instr_sltu      = flags_q[F_SLTU];
    assign instr_xor       = flags_q[F_XOR];
    assign instr_srl       = flags_q[F_SRL];
    assign instr_sra       = flags_q[F_SRA];
    assign instr_or        = flags_q[F_OR];
    assign instr_and       = flags_q[F_AND];
    assign instr_fence     = flags_q[F_FENCE];
    assign instr_fence_tso = flags_q[F_FENCE_TSO];
    assign instr_pause     = flags_q[F_PAUSE];
    assign instr_ecall     = flags_q[F_ECALL];
    assign instr_ebreak    = flags_q[F_EBREAK];
    assign instr_csrrw     = flags_q[F_CSRRW];
    assign instr_csrrs     = flags_q[F_CSRRS];
    assign instr_csrrc     = flags_q[F_CSRRC];
    assign instr_csrrwi    = flags_q[F_CSRRWI];
    assign instr_csrrsi    = flags_q[F_CSRRSI];
    assign instr_csrrci    = flags_q[F_CSRRCI];

endmodule

// File: tb/tb_rv32i_fetch_decode.sv
// Testbench for rv32i_fetch_decode: drives a scripted instruction memory and
// checks the held decode against a scoreboard of expected results.
module tb_rv32i_fetch_decode;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        retire;
    logic [31:0] next_pc;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        illegal, fetch_fault;
    logic instr_lui, instr_auipc, instr_jal, instr_jalr, instr_beq, instr_bne, instr_blt, instr_bge;
    logic instr_bltu, instr_bgeu, instr_lb, instr_lh, instr_lw, instr_lbu, instr_lhu, instr_sb;
    logic instr_sh, instr_sw, instr_addi, instr_slti, instr_sltiu, instr_xori, instr_ori, instr_andi;
    logic instr_slli, instr_srli, instr_srai, instr_add, instr_sub, instr_sll, instr_slt, instr_sltu;
    logic instr_xor, instr_srl, instr_sra, instr_or, instr_and, instr_fence, instr_fence_tso, instr_pause;
    logic instr_ecall, instr_ebreak, instr_csrrw, instr_csrrs, instr_csrrc, instr_csrrwi, instr_csrrsi, instr_csrrci;
    logic [47:0] dut_flags;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] word;
        int          flag;
        logic [31:0] imm;
        logic        ill;
        logic        flt;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    rv32i_fetch_decode #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
        .retire(retire), .next_pc(next_pc),
        .instr_valid(instr_valid), .pc(pc), .instr(instr), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .instr_lui(instr_lui), .instr_auipc(instr_auipc), .instr_jal(instr_jal), .instr_jalr(instr_jalr),
        .instr_beq(instr_beq), .instr_bne(instr_bne), .instr_blt(instr_blt), .instr_bge(instr_bge),
        .instr_bltu(instr_bltu), .instr_bgeu(instr_bgeu), .instr_lb(instr_lb), .instr_lh(instr_lh),
        .instr_lw(instr_lw), .instr_lbu(instr_lbu), .instr_lhu(instr_lhu), .instr_sb(instr_sb),
        .instr_sh(instr_sh), .instr_sw(instr_sw), .instr_addi(instr_addi), .instr_slti(instr_slti),
        .instr_sltiu(instr_sltiu), .instr_xori(instr_xori), .instr_ori(instr_ori), .instr_andi(instr_andi),
        .instr_slli(instr_slli), .instr_srli(instr_srli), .instr_srai(instr_srai), .instr_add(instr_add),
        .instr_sub(instr_sub), .instr_sll(instr_sll), .instr_slt(instr_slt), .instr_sltu(instr_sltu),
        .instr_xor(instr_xor), .instr_srl(instr_srl), .instr_sra(instr_sra), .instr_or(instr_or),
        .instr_and(instr_and), .instr_fence(instr_fence), .instr_fence_tso(instr_fence_tso),
        .instr_pause(instr_pause), .instr_ecall(instr_ecall), .instr_ebreak(instr_ebreak),
        .instr_csrrw(instr_csrrw), .instr_csrrs(instr_csrrs), .instr_csrrc(instr_csrrc),
        .instr_csrrwi(instr_csrrwi), .instr_csrrsi(instr_csrrsi), .instr_csrrci(instr_csrrci),
        .illegal(illegal), .fetch_fault(fetch_fault)
    );

    // Bit i matches the mnemonic order lui=0 ... csrrci=47.
    assign dut_flags = {instr_csrrci, instr_csrrsi, instr_csrrwi, instr_csrrc, instr_csrrs, instr_csrrw,
                        instr_ebreak, instr_ecall, instr_pause, instr_fence_tso, instr_fence,
                        instr_and, instr_or, instr_sra, instr_srl, instr_xor, instr_sltu, instr_slt,
                        instr_sll, instr_sub, instr_add, instr_srai, instr_srli, instr_slli,
                        instr_andi, instr_ori, instr_xori, instr_sltiu, instr_slti, instr_addi,
                        instr_sw, instr_sh, instr_sb, instr_lhu, instr_lbu, instr_lw, instr_lh, instr_lb,
                        instr_bgeu, instr_bltu, instr_bge, instr_blt, instr_bne, instr_beq,
                        instr_jalr, instr_jal, instr_auipc, instr_lui};

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Serve one fetch: optional ready stall, accept, 1-cycle response, then
    // compare the held decode against the scoreboard entry.
    task automatic fetch(input logic [31:0] word, input logic err, input int delay,
                         input int flag, input logic [31:0] imm_e);
        int n;
        logic [31:0] a0;
        exp_t e;
        logic [47:0] ef;
        n = 0;
        while (!imem_req_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("req_seen", 64'(imem_req_valid), 64'(1'b1));
        a0 = imem_req_addr;
        for (int i = 0; i < delay; i++) begin
            imem_req_ready = 1'b0;
            @(negedge clk);
            check_eq("addr_stable", 64'(imem_req_addr), 64'(a0));
            check_eq("req_held", 64'(imem_req_valid), 64'(1'b1));
        end
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        e.addr = a0; e.word = word; e.flag = flag; e.imm = imm_e;
        e.ill = (flag < 0) && !err; e.flt = err;
        sb.push_back(e);
        check_eq("wait_not_valid", 64'(instr_valid), 64'(1'b0));
        imem_rsp_valid = 1'b1; imem_rsp_data = word; imem_rsp_err = err;
        @(negedge clk);
        imem_rsp_valid = 1'b0; imem_rsp_err = 1'b0; imem_rsp_data = 32'hDEAD_BEEF;
        check_eq("valid_latency", 64'(instr_valid), 64'(1'b1));
        e = sb.pop_front();
        ef = (e.flag >= 0 && !e.flt) ? (48'd1 << e.flag) : 48'd0;
        check_eq("pc", 64'(pc), 64'(e.addr));
        check_eq("instr", 64'(instr), 64'(e.word));
        check_eq("flags", 64'(dut_flags), 64'(ef));
        check_eq("imm", 64'(imm), 64'(e.imm));
        check_eq("illegal", 64'(illegal), 64'(e.ill));
        check_eq("fault", 64'(fetch_fault), 64'(e.flt));
        check_eq("rd", 64'(rd), 64'(e.word[11:7]));
        check_eq("rs1", 64'(rs1), 64'(e.word[19:15]));
        check_eq("rs2", 64'(rs2), 64'(e.word[24:20]));
        check_eq("no_req_in_hold", 64'(imem_req_valid), 64'(1'b0));
    endtask

    task automatic retire_to(input logic [31:0] npc);
        retire = 1'b1; next_pc = npc;
        @(negedge clk);
        retire = 1'b0; next_pc = 32'h0;
        if (npc[1:0] == 2'b00) begin
            check_eq("retire_valid_low", 64'(instr_valid), 64'(1'b0));
            check_eq("retire_req", 64'(imem_req_valid), 64'(1'b1));
            check_eq("retire_addr", 64'(imem_req_addr), 64'(npc));
        end else begin
            check_eq("mis_valid", 64'(instr_valid), 64'(1'b1));
            check_eq("mis_fault", 64'(fetch_fault), 64'(1'b1));
            check_eq("mis_pc", 64'(pc), 64'(npc));
            check_eq("mis_instr", 64'(instr), 64'(32'h0));
            check_eq("mis_flags", 64'(dut_flags), 64'(48'h0));
            check_eq("mis_illegal", 64'(illegal), 64'(1'b0));
            check_eq("mis_no_req", 64'(imem_req_valid), 64'(1'b0));
        end
    endtask

    logic [31:0] t_word [14] = '{32'h8330_000F, 32'h0100_000F, 32'h0FF0_000F, 32'h0010_0073,
                                 32'h4020_5093, 32'h0040_A103, 32'h0020_A223, 32'hFE00_0EE3,
                                 32'h1234_50B7, 32'h4020_8033, 32'h3002_9073, 32'h0000_0073,
                                 32'h0220_0033, 32'hFFFF_FFFF};
    int          t_flag [14] = '{38, 39, 37, 41, 26, 12, 17, 4, 0, 28, 42, 40, -1, -1};
    logic [31:0] t_imm  [14] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h402, 32'h4, 32'h4, 32'hFFFF_FFFC,
                                 32'h1234_5000, 32'h0, 32'h300, 32'h0, 32'h0, 32'h0};

    initial begin
        logic [31:0] a;
        rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        imem_rsp_err = 1'b0; retire = 1'b0; next_pc = 32'h0;
        repeat (3) @(negedge clk);
        check_eq("rst_req", 64'(imem_req_valid), 64'(1'b0));
        check_eq("rst_valid", 64'(instr_valid), 64'(1'b0));
        check_eq("rst_pc", 64'(pc), 64'(32'h0));
        check_eq("rst_instr", 64'(instr), 64'(32'h0));
        check_eq("rst_imm", 64'(imm), 64'(32'h0));
        check_eq("rst_flags", 64'(dut_flags), 64'(48'h0));
        check_eq("rst_illegal", 64'(illegal), 64'(1'b0));
        check_eq("rst_fault", 64'(fetch_fault), 64'(1'b0));
        rst = 1'b0;
        @(negedge clk);
        check_eq("first_req", 64'(imem_req_valid), 64'(1'b1));
        check_eq("first_addr", 64'(imem_req_addr), 64'(32'h0));

        fetch(32'h0000_0013, 1'b0, 0, 18, 32'h0);
        retire_to(32'h4);
        fetch(32'h00C0_006F, 1'b0, 3, 2, 32'd12);
        retire_to(32'h100);

        a = 32'h100;
        for (int i = 0; i < 14; i++) begin
            fetch(t_word[i], 1'b0, i % 2, t_flag[i], t_imm[i]);
            a = a + 32'd4;
            retire_to(a);
        end

        fetch(32'h0000_0013, 1'b1, 1, -1, 32'h0);
        retire_to(32'h6);
        retire_to(32'h8);
        fetch(32'h0000_0013, 1'b0, 0, 18, 32'h0);
        retire_to(32'h0000_0040);

        // Reset while a response is arriving: it must be dropped.
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        rst = 1'b1; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0010_0073;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        check_eq("rw_valid", 64'(instr_valid), 64'(1'b0));
        check_eq("rw_req", 64'(imem_req_valid), 64'(1'b0));
        check_eq("rw_pc", 64'(pc), 64'(32'h0));
        check_eq("rw_flags", 64'(dut_flags), 64'(48'h0));
        rst = 1'b0;
        @(negedge clk);
        check_eq("rw_refetch_req", 64'(imem_req_valid), 64'(1'b1));
        check_eq("rw_refetch_addr", 64'(imem_req_addr), 64'(32'h0));
        fetch(32'h0000_0073, 1'b0, 0, 40, 32'h0);

        check_eq("sb_empty", 64'(sb.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rv32i_fetch_decode.md
# rv32i_fetch_decode

Multi-cycle instruction fetch and decode front end for the non-pipelined RV32I core. Holds the architectural PC, fetches one 32-bit word per instruction over a valid/ready request and valid response interface, then registers the decoded one-hot instruction flags, register indices and immediate. These outputs drive the combinational control unit and the datapath. The block holds one instruction stable until the core retires it and supplies the next PC.

## Interface
- RESET_PC, 32'h0000_0000, PC fetched first after reset; bits [1:0] must be 0
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- imem_req_valid  output  1  fetch request
- imem_req_ready  input  1  memory accepts request
- imem_req_addr  output  32  word-aligned fetch address, equals pc
- imem_rsp_valid  input  1  fetch data valid
- imem_rsp_data  input  32  instruction word
- imem_rsp_err  input  1  bus error, qualified by imem_rsp_valid
- retire  input  1  core finished current instruction
- next_pc  input  32  PC of next instruction, qualified by retire
- instr_valid  output  1  decoded outputs valid
- pc  output  32  PC of held instruction
- instr  output  32  raw instruction word
- rd, rs1, rs2  output  5 each  instr[11:7], [19:15], [24:20]
- imm  output  32  sign-extended immediate for the instruction's format; 0 for R-type, fence, system and illegal
- instr_<m>  output  1 each  one flag per mnemonic m: lui auipc jal jalr beq bne blt bge bltu bgeu lb lh lw lbu lhu sb sh sw addi slti sltiu xori ori andi slli srli srai add sub sll slt sltu xor srl sra or and fence fence_tso pause ecall ebreak csrrw csrrs csrrc csrrwi csrrsi csrrci
- illegal  output  1  held word matches no mnemonic
- fetch_fault  output  1  held word returned with imem_rsp_err, or next_pc misaligned

## Operation
- States: RESET, REQ, WAIT, HOLD.
- RESET: entered while rst=1. pc<=RESET_PC. All outputs 0 except pc. Moves to REQ on the first cycle with rst=0.
- REQ: imem_req_valid=1 and imem_req_addr=pc. Address is held stable until the handshake. On imem_req_ready=1 the request is accepted and the state moves to WAIT.
- WAIT: on imem_rsp_valid=1, capture instr, register the decode and move to HOLD.
  - If imem_rsp_err=1: fetch_fault=1 and all instr_* flags, illegal and imm are 0.
- HOLD: instr_valid=1. All decoded outputs stay constant.
  - On retire=1: pc<=next_pc and the state moves to REQ.
  - If next_pc[1:0]!=0: pc<=next_pc, the state stays in HOLD with fetch_fault=1, flags 0 and instr=0. Only a retire with an aligned next_pc leaves this fault condition.
- Response in RESET/REQ/HOLD: ignored. Retire outside HOLD: ignored.
- Decode (registered, one-hot; at most one flag set):
  - Opcode plus funct3, and funct7 where defined, per the RV32I base spec.
  - slli/srli/srai and R-type require the exact funct7 (0000000 or 0100000). Any other funct7 sets illegal.
  - fence_tso: fm=1000, pred=succ=0011, rs1=rd=0.
  - pause: fm=0000, pred=0001, succ=0000, rs1=rd=0.
  - fence: any other MISC-MEM word with funct3=000.
  - ecall = 32'h0000_0073 exactly; ebreak = 32'h0010_0073 exactly.
  - CSR ops use funct3 001/010/011/101/110/111 under opcode 1110011.
- illegal=1 iff HOLD, no fault, and no flag set.
- Immediates:
  - I: instr[31:20]
  - S: {[31:25],[11:7]}
  - B: {[31],[7],[30:25],[11:8],0}
  - U: {[31:12],12'b0}
  - J: {[31],[19:12],[20],[30:21],0}
  - All are sign-extended from instr[31]. CSR immediates (rs1 field as uimm) are left to the datapath; imm = I-format (CSR address).

## Timing
- Reset values: imem_req_valid=0, instr_valid=0, pc=RESET_PC, instr=0, imm=0, rd=rs1=rs2=0, all flags 0, illegal=0, fetch_fault=0.
- First request is asserted the cycle after rst falls.
- Best case, ready tied high with 1-cycle memory:
  - req accepted cycle t
  - rsp at t+1
  - instr_valid at t+2
- Retire at cycle n: instr_valid=0 at n+1 with imem_req_valid=1.
- The memory must be reset by the same rst, so no response from before reset arrives afterwards.
- rst=1 in any state returns to RESET on the next edge. Any in-flight request is abandoned.

## Test plan
- Reset, ready=1, 1-cycle memory returning 32'h0000_0013 -> imem_req_addr=0x0; instr_valid rises 2 cycles after acceptance; instr_addi=1, imm=0, rd=rs1=0.
- Hold 0x00C0_006F (jal x0,12), ready low for 3 cycles -> addr stable at pc throughout; then instr_jal=1, imm=12; retire with next_pc=0x100 -> next request addr=0x100.
- Words 0x8330_000F, 0x0100_000F, 0x0FF0_000F, 0x0010_0073, 0x4020_5093 -> fence_tso, pause, fence, ebreak, srai (imm=0x402) respectively.
- Word 0x0220_0033 (funct7=0000001) and 0xFFFF_FFFF -> illegal=1, all flags 0.
- Response with imem_rsp_err=1 -> fetch_fault=1, illegal=0, flags 0; retire with next_pc=0x6 -> fault held; retire with next_pc=0x8 -> fetch of 0x8.
- rst asserted in WAIT, response arrives same cycle -> response ignored; after rst falls, re-fetch from RESET_PC.
